video_char_sink: RTL and testbench
==================================

Name: video_char_sink

Overview:
- Responder end of the CPU video-write interface (videoflag / vga_pos / vga_char) driven by cpu_v.
- Captures each CPU character write, buffers it in a small FIFO and commits it to an internal screen memory of SCREEN_CELLS 16-bit words.
- Provides a synchronous read port for the raster scanner.
- Sits between cpu_v and the VGA timing/scanout logic, in the same clock domain as the CPU.

Parameters:
- SCREEN_CELLS, 1200, number of character cells (40x30); valid positions 0..SCREEN_CELLS-1.
- FIFO_DEPTH, 4, write-buffer entries; power of two, >= 2.
- ADDR_W, 11, screen address width; ceil(log2(SCREEN_CELLS)).

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- videoflag  in  1  CPU video write strobe (level; one write per rising edge of the level).
- vga_pos  in  16  cell position, sampled on the videoflag rising-edge cycle.
- vga_char  in  16  character/colour word, sampled with vga_pos.
- busy  out  1  high when FIFO full or block in CLEAR state.
- ready  out  1  high in RUN state.
- fifo_level  out  3  current FIFO occupancy, 0..FIFO_DEPTH.
- dropped_count  out  8  saturating count of discarded writes.
- scan_pos  in  ADDR_W  scanner read address.
- scan_char  out  16  screen word at scan_pos, one-cycle latency.

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clear_addr=0, FIFO empty, fifo_level=0, flag_d=0, dropped_count=0, scan_char=0, busy=1, ready=0.
- Edge detect: flag_d <= videoflag every cycle; write_evt = videoflag & ~flag_d. A videoflag already high on the first cycle after reset release counts as an event.
- On write_evt in cycle N:
  - If vga_pos >= SCREEN_CELLS: discard and increment dropped_count.
  - Else if the FIFO is full and no pop occurs in cycle N: discard and increment dropped_count.
  - Otherwise push {vga_pos[ADDR_W-1:0], vga_char} at the end of cycle N.
- dropped_count saturates at 255 and never wraps.
- FSM:
  - CLEAR: each cycle writes 0x0000 to mem[clear_addr] and increments clear_addr. After writing address SCREEN_CELLS-1, go to RUN. CLEAR lasts exactly SCREEN_CELLS cycles. No FIFO pops in CLEAR; pushes still accepted until full.
  - RUN: if the FIFO is non-empty, pop the head and write mem[pos] <= char in the same cycle, one entry per cycle. Stays in RUN until reset.
- Push and pop in the same cycle: both occur and fifo_level is unchanged, including when full (push accepted).
- Latency in RUN with an empty FIFO: event in cycle N; entry present in cycle N+1; memory written at the end of N+1. A scan read of that pos presented in cycle N+2 returns the new char on scan_char in cycle N+3.
- Scan port:
  - scan_char <= mem[scan_pos] every cycle.
  - Read-during-write to the same address returns old data (read-first).
  - scan_pos >= SCREEN_CELLS returns 0x0000.
- Successive writes to the same pos commit in order; the last one wins.
- busy = (fifo_level==FIFO_DEPTH) | (state==CLEAR). ready = (state==RUN). Both are combinational from registered state.
- Reset mid-operation: FIFO contents lost and a new CLEAR sweep starts; memory is re-zeroed by that sweep.

Test Plan:
- Release reset with videoflag=0 -> busy=1, ready=0 for exactly 1200 cycles, then ready=1, busy=0. Scan every address -> 0x0000.
- In RUN: pulse videoflag with pos=5, char=0x0A41 -> fifo_level 1 for one cycle then 0. scan_pos=5 -> scan_char=0x0A41 at N+3.
- Hold videoflag high for 10 cycles with pos=7, char=0x0042 -> exactly one write. dropped_count unchanged.
- During CLEAR, issue 6 writes to pos 0..5 -> first 4 buffered, fifo_level=4, busy=1, dropped_count=2. After RUN starts, cells 0..3 hold the written chars and cells 4..5 read 0x0000.
- Write pos=1200 and then pos=0xFFFF -> both discarded, dropped_count=2, no memory change. Drive 300 invalid writes -> dropped_count stays 255.
- Assert reset mid-CLEAR at clear_addr=600 with 2 entries buffered -> fifo_level=0, dropped_count=0 immediately. A new 1200-cycle CLEAR follows and all cells read 0x0000.

Source files
------------

// File: rtl/video_char_sink_if.sv
// video_char_sink_if: CPU video-write strobe/position/character bus plus responder status.
interface video_char_sink_if;
    logic        videoflag;
    logic [15:0] vga_pos;
    logic [15:0] vga_char;
    logic        busy;
    logic        ready;
    modport master (output videoflag, vga_pos, vga_char, input busy, ready);
    modport slave (input videoflag, vga_pos, vga_char, output busy, ready);
endinterface

// File: rtl/video_char_sink.sv
// video_char_sink: buffers CPU character writes in a FIFO and commits them to screen memory with a scanner read port.
module video_char_sink #(
    parameter int SCREEN_CELLS = 1200,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W = 11
) (
    input  logic                               clock,
    input  logic                               reset,
    video_char_sink_if.slave                   cpu,
    output logic [$clog2(FIFO_DEPTH + 1)-1:0]  fifo_level,
    output logic [7:0]                         dropped_count,
    input  logic [ADDR_W-1:0]                  scan_pos,
    output logic [15:0]                        scan_char
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = ADDR_W + 16;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(SCREEN_CELLS - 1);
    localparam logic [15:0] CELLS = 16'(SCREEN_CELLS);
    localparam logic [LVL_W-1:0] FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clear_addr;
    logic              flag_d;
    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [15:0]       screen [SCREEN_CELLS];
    logic              write_evt, full, pop, push, drop, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;

    // A full FIFO still accepts a push when the head drains in the same cycle.
    always_comb begin
        write_evt  = cpu.videoflag & ~flag_d;
        full       = fifo_level == FULL;
        pop        = state == RUN && fifo_level != '0;
        push       = write_evt && cpu.vga_pos < CELLS && (!full || pop);
        drop       = write_evt && !push;
        state_next = (state == CLEAR && clear_addr == LAST_CELL) ? RUN : state;
        mem_we     = state == CLEAR || pop;
        mem_addr   = state == CLEAR ? clear_addr : fifo_mem[rd_ptr][ENT_W-1:16];
        mem_data   = state == CLEAR ? 16'h0000 : fifo_mem[rd_ptr][15:0];
    end

    assign cpu.busy  = full | (state == CLEAR);
    assign cpu.ready = state == RUN;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= CLEAR;
            clear_addr    <= '0;
            flag_d        <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            dropped_count <= '0;
            scan_char     <= '0;
        end else begin
            state         <= state_next;
            clear_addr    <= state == CLEAR ? clear_addr + ADDR_W'(1) : clear_addr;
            flag_d        <= cpu.videoflag;
            wr_ptr        <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
            rd_ptr        <= pop ? rd_ptr + PTR_W'(1) : rd_ptr;
            fifo_level    <= fifo_level + LVL_W'(push) - LVL_W'(pop);
            dropped_count <= (drop && dropped_count != 8'hFF) ? dropped_count + 8'd1 : dropped_count;
            scan_char     <= scan_pos <= LAST_CELL ? screen[scan_pos] : 16'h0000;
        end
    end

    // Storage arrays carry no reset so they map onto RAM; CLEAR re-zeroes the screen.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= {cpu.vga_pos[ADDR_W-1:0], cpu.vga_char};
        if (mem_we)
            screen[mem_addr] <= mem_data;
    end
endmodule

// File: tb/tb_video_char_sink.sv
// tb_video_char_sink: directed stimulus with a scan-port scoreboard checked by an independent monitor.
module tb_video_char_sink;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  fifo_level;
    logic [7:0]  dropped_count;
    logic [10:0] scan_pos = '0;
    logic [15:0] scan_char;
    logic        scan_req = 1'b0;
    logic        req_d = 1'b0;
    int          checks = 0;
    int          passes = 0;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    video_char_sink_if bus();

    video_char_sink dut (
        .clock(clock),
        .reset(reset),
        .cpu(bus),
        .fifo_level(fifo_level),
        .dropped_count(dropped_count),
        .scan_pos(scan_pos),
        .scan_char(scan_char)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    always @(posedge clock) req_d <= scan_req;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (req_d) begin
            if (exp_q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk($sformatf("scan[%0d]", e.addr), {16'h0, scan_char}, {16'h0, e.data});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic scan(input logic [10:0] a, input logic [15:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        scan_pos = a;
        scan_req = 1'b1;
        exp_q.push_back(e);
        @(negedge clock);
        scan_req = 1'b0;
    endtask

    task automatic write(input logic [15:0] p, input logic [15:0] c);
        bus.videoflag = 1'b1;
        bus.vga_pos = p;
        bus.vga_char = c;
        @(negedge clock);
        bus.videoflag = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!bus.ready && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk("wait_ready", {31'h0, bus.ready}, 32'd1);
    endtask

    task automatic clear_timing(input string tag);
        cyc(1199);
        chk({tag, "_ready_1199"}, {31'h0, bus.ready}, 32'd0);
        chk({tag, "_busy_1199"}, {31'h0, bus.busy}, 32'd1);
        cyc(1);
        chk({tag, "_ready_1200"}, {31'h0, bus.ready}, 32'd1);
        chk({tag, "_busy_1200"}, {31'h0, bus.busy}, 32'd0);
    endtask

    task automatic scan_all_zero(input string tag);
        for (int i = 0; i < 1200; i++) scan(11'(i), 16'h0000);
        scan(11'd1200, 16'h0000);
        scan(11'd2047, 16'h0000);
        cyc(1);
        chk({tag, "_scoreboard_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.videoflag = 1'b0;
        bus.vga_pos = '0;
        bus.vga_char = '0;
        cyc(3);
        chk("rst_busy", {31'h0, bus.busy}, 32'd1);
        chk("rst_ready", {31'h0, bus.ready}, 32'd0);
        chk("rst_level", {29'h0, fifo_level}, 32'd0);
        chk("rst_dropped", {24'h0, dropped_count}, 32'd0);
        chk("rst_scan_char", {16'h0, scan_char}, 32'd0);
        reset = 1'b1;
        clear_timing("clear1");
        scan_all_zero("clear1");

        // writes during CLEAR: four buffered, two dropped
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) write(16'(i), 16'h1100 + 16'(i));
        chk("clrw_level", {29'h0, fifo_level}, 32'd4);
        chk("clrw_busy", {31'h0, bus.busy}, 32'd1);
        chk("clrw_dropped", {24'h0, dropped_count}, 32'd2);
        wait_ready(1300);
        cyc(6);
        chk("clrw_drained", {29'h0, fifo_level}, 32'd0);
        for (int i = 0; i < 4; i++) scan(11'(i), 16'h1100 + 16'(i));
        scan(11'd4, 16'h0000);
        scan(11'd5, 16'h0000);

        // single write latency with a read-first probe on the commit cycle
        bus.videoflag = 1'b1;
        bus.vga_pos = 16'd5;
        bus.vga_char = 16'h0A41;
        cyc(1);
        chk("lat_level_n1", {29'h0, fifo_level}, 32'd1);
        bus.videoflag = 1'b0;
        scan(11'd5, 16'h0000);
        chk("lat_level_n2", {29'h0, fifo_level}, 32'd0);
        scan(11'd5, 16'h0A41);

        // level held high produces exactly one write
        bus.videoflag = 1'b1;
        bus.vga_pos = 16'd7;
        bus.vga_char = 16'h0042;
        cyc(1);
        chk("hold_level_first", {29'h0, fifo_level}, 32'd1);
        for (int i = 1; i < 10; i++) begin
            cyc(1);
            chk($sformatf("hold_level_%0d", i), {29'h0, fifo_level}, 32'd0);
        end
        bus.videoflag = 1'b0;
        chk("hold_dropped", {24'h0, dropped_count}, 32'd2);
        scan(11'd7, 16'h0042);

        write(16'd9, 16'h1111);
        write(16'd9, 16'h2222);
        cyc(2);
        scan(11'd9, 16'h2222);

        // out-of-range positions are dropped and never reach memory
        write(16'd1200, 16'hBEEF);
        write(16'hFFFF, 16'hDEAD);
        chk("inv_dropped", {24'h0, dropped_count}, 32'd4);
        chk("inv_level", {29'h0, fifo_level}, 32'd0);
        cyc(2);
        scan(11'd0, 16'h1100);
        scan(11'd1199, 16'h0000);
        scan(11'd5, 16'h0A41);
        for (int i = 0; i < 251; i++) write(16'h8000, 16'h0000);
        chk("sat_reach", {24'h0, dropped_count}, 32'd255);
        for (int i = 0; i < 49; i++) write(16'h8000, 16'h0000);
        chk("sat_hold", {24'h0, dropped_count}, 32'd255);
        cyc(1);
        chk("mid_scoreboard_empty", exp_q.size(), 32'd0);

        // reset in the middle of a CLEAR sweep with entries buffered
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        write(16'd20, 16'h3333);
        write(16'd21, 16'h4444);
        write(16'd1500, 16'h0000);
        chk("mid_level_pre", {29'h0, fifo_level}, 32'd2);
        chk("mid_dropped_pre", {24'h0, dropped_count}, 32'd1);
        cyc(594);
        chk("mid_ready_600", {31'h0, bus.ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_level_rst", {29'h0, fifo_level}, 32'd0);
        chk("mid_dropped_rst", {24'h0, dropped_count}, 32'd0);
        chk("mid_busy_rst", {31'h0, bus.busy}, 32'd1);
        cyc(2);
        reset = 1'b1;
        clear_timing("clear2");
        cyc(2);
        chk("clear2_level", {29'h0, fifo_level}, 32'd0);
        scan_all_zero("clear2");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
